// File: rtl/sc_core_oz_pkg.sv
// Shared types for the sc_core_oz execute stage: M-extension opcodes,
// multiply/divide sequencer states and the iteration count.
`timescale 1ns/1ps
package sc_core_oz_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } m_md_op;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } m_md_state;

    localparam int MD_ITER = 32;

endpackage

// File: rtl/sc_core_oz_md_step.sv
// One radix-2 iteration on the 64-bit accumulator: shift-add for multiply,
// restoring shift-subtract for divide.
`timescale 1ns/1ps
module sc_core_oz_md_step #(
    parameter int XLEN = 32
) (
    input  logic                mode_div,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] diff;

    // sum keeps the carry so it lands in bit 2*XLEN-1 after the right shift
    assign sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
    // the partial remainder after the left shift needs XLEN+1 bits
    assign diff = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};

    always_comb begin
        acc_next = acc;
        if (!mode_div) begin
            if (acc[0]) acc_next = {sum, acc[XLEN-1:1]};
            else        acc_next = {1'b0, acc[2*XLEN-1:1]};
        end else begin
            if (!diff[XLEN]) acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else             acc_next = {acc[2*XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/sc_core_oz_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer with request/response handshakes,
// early-exit special cases and a one-cycle sign fix-up stage.
`timescale 1ns/1ps
module sc_core_oz_muldiv_seq
    import sc_core_oz_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit FAST_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic [4:0]      rsp_rd,
    output logic            busy
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic en);
        return en ? ('0 - v) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_dw(input logic [2*XLEN-1:0] v, input logic en);
        return en ? ('0 - v) : v;
    endfunction

    m_md_state          state_q, state_d;
    m_md_op             op_in, op_q;
    logic [4:0]         rd_q;
    logic               neg_q;
    logic [5:0]         cnt_q;
    logic [2*XLEN-1:0]  acc_q, acc_step, acc_init, prod_fix;
    logic [XLEN-1:0]    opnd_q, opnd_init;
    logic [XLEN-1:0]    result_q, special_res, fix_res, quo_fix, rem_fix;
    logic [XLEN-1:0]    src1_abs, src2_abs;
    logic signed [XLEN-1:0] src1_s, src2_s;
    logic               s1_signed, s2_signed, neg1, neg2, neg_in;
    logic               accept, special, div_zero, div_ovf, mul_zero;

    assign op_in  = m_md_op'(req_op);
    assign src1_s = req_src1;
    assign src2_s = req_src2;
    assign accept = req_valid && (state_q == IDLE) && !flush;

    // Operand conditioning and early-exit decode on the incoming request
    always_comb begin
        s1_signed   = op_in inside {MULH, MULHSU, DIV, REM};
        s2_signed   = op_in inside {MULH, DIV, REM};
        neg1        = s1_signed && (src1_s < 0);
        neg2        = s2_signed && (src2_s < 0);
        src1_abs    = cond_neg(req_src1, neg1);
        src2_abs    = cond_neg(req_src2, neg2);
        neg_in      = 1'b0;
        case (op_in)
            MUL, MULH, MULHSU, MULHU, DIV: neg_in = neg1 ^ neg2;
            REM:                           neg_in = neg1;
            default:                       neg_in = 1'b0;
        endcase

        div_zero    = req_op[2] && (req_src2 == '0);
        div_ovf     = (op_in inside {DIV, REM}) && (req_src1 == INT_MIN) && (req_src2 == '1);
        mul_zero    = FAST_ZERO && !req_op[2] && ((req_src1 == '0) || (req_src2 == '0));
        special     = div_zero || div_ovf || mul_zero;

        special_res = '0;
        if (div_zero)     special_res = req_op[1] ? req_src1 : '1;
        else if (div_ovf) special_res = req_op[1] ? '0 : INT_MIN;

        // multiply keeps the multiplier in the low half, divide the dividend
        if (req_op[2]) begin
            acc_init  = {{XLEN{1'b0}}, src1_abs};
            opnd_init = src2_abs;
        end else begin
            acc_init  = {{XLEN{1'b0}}, src2_abs};
            opnd_init = src1_abs;
        end
    end

    sc_core_oz_md_step #(.XLEN(XLEN)) u_step (
        .mode_div (op_q[2]),
        .acc      (acc_q),
        .operand  (opnd_q),
        .acc_next (acc_step)
    );

    always_comb begin
        prod_fix = cond_neg_dw(acc_q, neg_q);
        quo_fix  = cond_neg(acc_q[XLEN-1:0], neg_q);
        rem_fix  = cond_neg(acc_q[2*XLEN-1:XLEN], neg_q);
        case (op_q)
            MUL:                 fix_res = prod_fix[XLEN-1:0];
            MULH, MULHSU, MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            DIV, DIVU:           fix_res = quo_fix;
            default:             fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (cnt_q == 6'(MD_ITER - 1)) state_d = FIXUP;
            FIXUP:   state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Control and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rd_q  <= req_rd;
                cnt_q <= '0;
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q + 6'd1;
            end
            if (accept && special)                 result_q <= special_res;
            else if (state_q == FIXUP && !flush)   result_q <= fix_res;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= op_in;
            neg_q  <= neg_in;
            acc_q  <= acc_init;
            opnd_q <= opnd_init;
        end else if (state_q == CALC) begin
            acc_q  <= acc_step;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign rsp_result = result_q;
    assign rsp_rd     = rd_q;

endmodule

// File: tb/tb_sc_core_oz_muldiv_seq.sv
// Scoreboard bench for the multiply/divide sequencer: directed vectors,
// backpressure, flush and mid-operation reset.
`timescale 1ns/1ps
module tb_sc_core_oz_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_src1, req_src2;
    logic [4:0]  req_rd;
    logic        flush;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_rd;
    logic        busy;

    sc_core_oz_muldiv_seq #(.XLEN(32), .FAST_ZERO(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .req_rd     (req_rd),
        .flush      (flush),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_rd     (rsp_rd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   rise_cyc = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake
    always @(negedge clk) begin
        if (rsp_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_rd), 32'h0000_00ff);
            end else begin
                mon_e = sbq.pop_front();
                check("result", rsp_result, mon_e.res);
                check("rd", 32'(rsp_rd), 32'(mon_e.rd));
                check("latency", 32'(rise_cyc - mon_e.acc_cyc), 32'(mon_e.lat));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                         input bit push, output int acc_cyc);
        exp_t e;
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        req_rd    = rd;
        acc_cyc   = -1;
        for (int i = 0; i < 200; i++) begin
            if (req_ready && !flush) begin
                acc_cyc = cyc;
                if (push) begin
                    e = '{exp_res, rd, exp_lat, cyc};
                    sbq.push_back(e);
                end
                break;
            end
            step();
        end
        if (acc_cyc < 0) check("accept_timeout", 32'd0, 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sbq.size() == 0 && !rsp_valid) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) begin
            check("drain_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    localparam int NV = 14;
    logic [2:0]  v_op  [NV] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                3'd5, 3'd6, 3'd4, 3'd0, 3'd6, 3'd1};
    logic [31:0] v_a   [NV] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                32'h1234, 32'h1234, 32'h8000_0000, 32'd0,
                                32'h8000_0000, 32'hFFFF_FFFD};
    logic [31:0] v_b   [NV] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd2, 32'd2, 32'd7, 32'd7,
                                32'd0, 32'd0, 32'hFFFF_FFFF, 32'd5,
                                32'hFFFF_FFFF, 32'd7};
    logic [31:0] v_exp [NV] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0,
                                32'd0, 32'hFFFF_FFFF};
    int          v_lat [NV] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1, 1, 34};

    initial begin
        int acc_c;
        int rel_c;
        int seen;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_src1  = '0;
        req_src2  = '0;
        req_rd    = '0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        step();
        step();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_rd", 32'(rsp_rd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < NV; i++) begin
            issue(v_op[i], v_a[i], v_b[i], 5'(i + 1), v_exp[i], v_lat[i], 1'b1, acc_c);
            wait_drain();
        end

        // Backpressure in DONE, then a request queued behind the handshake
        rsp_ready = 1'b0;
        issue(3'd5, 32'd100, 32'd7, 5'd20, 32'd14, 34, 1'b1, acc_c);
        for (int i = 0; i < 60 && !rsp_valid; i++) step();
        check("bp_reached_done", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_result", rsp_result, 32'd14);
            check("bp_rsp_rd", 32'(rsp_rd), 32'd20);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        rel_c = cyc;
        issue(3'd7, 32'd100, 32'd7, 5'd21, 32'd2, 34, 1'b1, acc_c);
        check("b2b_accept_cycle", 32'(acc_c), 32'(rel_c + 1));
        wait_drain();

        // Flush at CALC iteration 10
        issue(3'd0, 32'd3, 32'd5, 5'd9, 32'd15, 34, 1'b0, acc_c);
        repeat (10) step();
        check("pre_flush_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_rsp_valid", 32'(rsp_valid), 32'd0);
        check("flush_req_ready", 32'(req_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) seen++;
            step();
        end
        check("flush_no_rsp", 32'(seen), 32'd0);

        // Flush in IDLE blocks an accept
        req_valid = 1'b1;
        req_op    = 3'd5;
        req_src1  = 32'd9;
        req_src2  = 32'd3;
        flush     = 1'b1;
        step();
        req_valid = 1'b0;
        flush     = 1'b0;
        check("idle_flush_no_accept", 32'(busy), 32'd0);

        // Reset mid-CALC of a fresh DIV
        issue(3'd4, 32'd100, 32'd7, 5'd17, 32'd14, 34, 1'b0, acc_c);
        repeat (5) step();
        rst = 1'b1;
        step();
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_result", rsp_result, 32'd0);
        check("mid_rst_rsp_rd", 32'(rsp_rd), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid || busy) seen++;
            step();
        end
        check("mid_rst_stays_idle", 32'(seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_core_oz_muldiv_seq.md
Name: sc_core_oz_muldiv_seq

Overview:
Iterative RV32M multiply/divide sequencer that sits beside the single-cycle ALU in the sc_core_oz execute stage.
- Accepts one M-extension operation over a valid/ready request handshake.
- Runs a radix-2 shift-add (MUL*) or restoring shift-subtract (DIV*/REM*) loop, one bit per cycle.
- Applies sign fix-up, then holds the result on a valid/ready response handshake until the core writes it back.
- The core stalls its PC while busy is high.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
FAST_ZERO, 1, when 1 a MUL* with either operand equal to 0 completes on the early-exit path.

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept (high only in IDLE)
req_op  input  3  m_md_op (funct3 encoding)
req_src1  input  32  rs1 value
req_src2  input  32  rs2 value
req_rd  input  5  destination register tag
flush  input  1  abandon current operation (branch/exception kill)
rsp_valid  output  1  result available
rsp_ready  input  1  core consumes result
rsp_result  output  32  result
rsp_rd  output  5  destination tag echoed from request
busy  output  1  high in every state except IDLE

Behaviour:
- Clocking: one clock, clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_rd=0, busy=0. Reset mid-operation discards all state.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - Accept when req_valid&&req_ready. Latch op and rd.
  - Latch |src| per op signedness: MULH/DIV/REM both signed; MULHSU src1 signed, src2 unsigned; others unsigned.
  - Latch result-negate flags:
    - MUL*: sign1 XOR sign2.
    - DIV: sign1 XOR sign2.
    - REM: sign1.
- Special cases decided at accept go IDLE->DONE directly; rsp_valid rises on the next edge:
  - DIV/DIVU by 0: quotient=0xFFFFFFFF.
  - REM/REMU by 0: remainder=src1.
  - DIV 0x80000000 / 0xFFFFFFFF: quotient=0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF: remainder=0.
  - FAST_ZERO=1 and MUL* with a zero operand: result=0.
- Normal path: IDLE->CALC with a 6-bit counter=0.
- CALC: one iteration per cycle on a 64-bit accumulator.
  - Multiply: if multiplier LSB is 1, add the multiplicand into the upper half, then shift right 1.
  - Divide: shift the remainder:quotient pair left 1; trial-subtract the divisor; if no borrow, keep the difference and set quotient bit.
  - After iteration 31 (counter==31), go to FIXUP.
- FIXUP: one cycle. Two's-complement negate the 64-bit product or the quotient/remainder if its flag is set. Select the result word:
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Then go to DONE.
- DONE: rsp_valid=1. rsp_result and rsp_rd are stable while rsp_valid && !rsp_ready. On rsp_ready, go to IDLE; rsp_valid falls next cycle.
- Latency: accept edge T; CALC T+1..T+32; FIXUP T+33; rsp_valid high from T+34 (34 cycles). Early-exit path: rsp_valid high from T+1.
- Throughput: no new request is accepted in the DONE-handshake cycle; the next accept is earliest 1 cycle after rsp handshake.
- flush: in any state, the next state is IDLE and rsp_valid=0 next cycle; the result is dropped. Reset has priority over flush. flush in IDLE with req_valid high blocks the accept that cycle.
- Arithmetic is modulo 2^32 on results. No exceptions are raised.

Decomposition:
- In sc_core_oz_pkg:
  - typedef enum logic [2:0] m_md_op {MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7}.
  - typedef enum m_md_state {IDLE, CALC, FIXUP, DONE}.
  - Constant MD_ITER=32.
- One natural sub-module: sc_core_oz_md_step, the combinational single iteration (add-shift or subtract-shift of the 64-bit accumulator, selected by mode bit). The FSM, counter, and fix-up stay in the parent.

Test Plan:
- MUL 7 * 0xFFFFFFFD -> rsp_result 0xFFFFFFEB, rsp_valid exactly 34 cycles after accept, rsp_rd echoed.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Early-exit cases, each with rsp_valid 1 cycle after accept:
  - DIVU 0x1234 / 0 -> 0xFFFFFFFF.
  - REM 0x1234 / 0 -> 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - MUL 0 * 5 -> 0.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_result, rsp_rd stable, req_ready=0. Release -> IDLE, then a back-to-back request is accepted.
- Flush at CALC iteration 10 -> IDLE next cycle, no rsp_valid. Then rst asserted mid-CALC of a fresh DIV -> all outputs at reset values the next cycle.
